// File: rtl/enc8x3_stream.sv
// Streaming priority encoder: accepts a request vector and emits the index of each set bit, one beat per handshake.
// Define ENC_MSB_FIRST_EN to scan from the highest set bit down instead of the lowest up.
module enc8x3_stream #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         out_none
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] mask_q, mask_d;
  logic         valid_q, valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic         last_q, last_d;
  logic         none_q, none_d;
  logic [N-1:0] remain;

  // The loop direction makes the winning bit the last one assigned.
  function automatic logic [W-1:0] pick(input logic [N-1:0] v);
    logic [W-1:0] r;
    r = '0;
`ifdef ENC_MSB_FIRST_EN
    for (int i = 0; i < N; i++) begin
      if (v[i]) r = W'(i);
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) r = W'(i);
    end
`endif
    return r;
  endfunction

  function automatic logic single_bit(input logic [N-1:0] v);
    return (v != '0) && ((v & (v - N'(1))) == '0);
  endfunction

  assign remain = mask_q & ~(N'(1) << idx_q);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    last_d  = last_q;
    none_d  = none_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = EMIT;
          mask_d  = in_vec;
          valid_d = 1'b1;
          if (in_vec != '0) begin
            idx_d  = pick(in_vec);
            last_d = single_bit(in_vec);
            none_d = 1'b0;
          end else begin
            idx_d  = '0;
            last_d = 1'b1;
            none_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (valid_q && out_ready) begin
          mask_d = remain;
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            none_d  = 1'b0;
          end else begin
            idx_d  = pick(remain);
            last_d = single_bit(remain);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      none_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      none_q  <= none_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign out_none  = none_q;

endmodule

// File: tb/tb_enc8x3_stream.sv
// Scoreboard bench for enc8x3_stream: stimulus queues hand-computed beats, a monitor pops them on each handshake.
module tb_enc8x3_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_last;
  logic       out_none;

  int total = 0;
  int bad   = 0;

  logic [4:0] exp_q[$];
  logic       stall_prev = 1'b0;
  logic [4:0] stall_val  = '0;

  enc8x3_stream #(.N(8), .W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_vec   (in_vec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx  (out_idx),
    .out_last (out_last),
    .out_none (out_none)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic expb(input logic [2:0] idx, input logic last, input logic none);
    exp_q.push_back({idx, last, none});
  endtask

  // Present a vector when the block is ready; returns 1 cycle after the accepting edge.
  task automatic send(input logic [7:0] v);
    int n = 0;
    while (!in_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_vec   = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("first_beat_valid", {31'd0, out_valid}, 32'd1);
    check("busy_in_ready", {31'd0, in_ready}, 32'd0);
    $display("send vec=%02h", v);
  endtask

  task automatic wait_idle(input logic toggle);
    int n = 0;
    while (!in_ready && n < 60) begin
      @(posedge clk); #1;
      if (toggle) out_ready = ~out_ready;
      n++;
    end
    check("return_idle", {31'd0, in_ready}, 32'd1);
  endtask

  // Monitor: a beat is taken at the posedge following a negedge where valid&&ready.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev && out_valid)
        check("stall_hold", {27'd0, out_idx, out_last, out_none}, {27'd0, stall_val});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got idx=%0d last=%0b none=%0b want none", out_idx, out_last, out_none);
        end else begin
          logic [4:0] e;
          e = exp_q.pop_front();
          $display("beat idx=%0d last=%0b none=%0b", out_idx, out_last, out_none);
          check("beat", {27'd0, out_idx, out_last, out_none}, {27'd0, e});
        end
      end
      stall_prev <= out_valid && !out_ready;
      stall_val  <= {out_idx, out_last, out_none};
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b0;
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_idx", {29'd0, out_idx}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_out_none", {31'd0, out_none}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Three beats back to back, then idle exactly after the last one.
    out_ready = 1'b1;
`ifdef ENC_MSB_FIRST_EN
    expb(3'd7, 1'b0, 1'b0); expb(3'd5, 1'b0, 1'b0); expb(3'd2, 1'b1, 1'b0);
`else
    expb(3'd2, 1'b0, 1'b0); expb(3'd5, 1'b0, 1'b0); expb(3'd7, 1'b1, 1'b0);
`endif
    send(8'b1010_0100);
    @(posedge clk); #1;
    check("a4_beat2_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    check("a4_beat3_valid", {31'd0, out_valid}, 32'd1);
    check("a4_beat3_busy", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("a4_done_valid", {31'd0, out_valid}, 32'd0);
    check("a4_done_ready", {31'd0, in_ready}, 32'd1);

    // Single bit with a 3-cycle stall.
    out_ready = 1'b0;
    expb(3'd4, 1'b1, 1'b0);
    send(8'b0001_0000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("single_done_valid", {31'd0, out_valid}, 32'd0);
    check("single_done_ready", {31'd0, in_ready}, 32'd1);

    // All-zero vector.
    expb(3'd0, 1'b1, 1'b1);
    send(8'h00);
    wait_idle(1'b0);

    // All ones with toggling out_ready and a competing vector held on the input.
`ifdef ENC_MSB_FIRST_EN
    for (int i = 7; i >= 0; i--) expb(3'(i), (i == 0), 1'b0);
`else
    for (int i = 0; i < 8; i++) expb(3'(i), (i == 7), 1'b0);
`endif
    out_ready = 1'b0;
    send(8'hFF);
    in_valid = 1'b1;
    in_vec   = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      out_ready = ~out_ready;
      check("ff_no_accept", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    wait_idle(1'b1);
    @(posedge clk); #1;

    // Reset mid-stream after the 2nd beat.
    out_ready = 1'b1;
`ifdef ENC_MSB_FIRST_EN
    for (int i = 7; i >= 0; i--) expb(3'(i), (i == 0), 1'b0);
`else
    for (int i = 0; i < 8; i++) expb(3'(i), (i == 7), 1'b0);
`endif
    send(8'hFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_idx", {29'd0, out_idx}, 32'd0);
    check("mid_rst_last", {31'd0, out_last}, 32'd0);
    check("drained_before_rst", exp_q.size(), 32'd6);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef ENC_MSB_FIRST_EN
    expb(3'd7, 1'b0, 1'b0); expb(3'd0, 1'b1, 1'b0);
`else
    expb(3'd0, 1'b0, 1'b0); expb(3'd7, 1'b1, 1'b0);
`endif
    send(8'h81);
    wait_idle(1'b0);
    @(posedge clk); #1;
    check("queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
